regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-entry busy scoreboard: two combinational read ports
// with write-first bypass, one writeback port, and issue/flush busy tracking.
module regfile_sb #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                GP_IDX  = 28,
    parameter int                SP_IDX  = 29,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_2ffc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              ovf,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    input  logic              issue_vld,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_en;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            c = c + {{ADDR_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Overflow blocks the data write (and bypass) but not the busy clear.
    assign wr_en = we && !ovf && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i == GP_IDX) ? GP_INIT :
                          (i == SP_IDX) ? SP_INIT : '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // Ordering flush -> writeback clear -> issue set lets a new issue win.
    always_comb begin
        busy_nxt = busy;
        if (flush)
            busy_nxt = '0;
        if (we)
            busy_nxt[wa] = 1'b0;
        if (issue_vld)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    always_comb begin
        bus_a = mem[ra];
        if (ra == '0)
            bus_a = '0;
        else if (wr_en && (wa == ra))
            bus_a = wd;
    end

    always_comb begin
        bus_b = mem[rb];
        if (rb == '0)
            bus_b = '0;
        else if (wr_en && (wa == rb))
            bus_b = wd;
    end

    assign busy_a = busy[ra] && !(we && (wa == ra));
    assign busy_b = busy[rb] && !(we && (wa == rb));

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against an array-based model.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, ovf, flush, issue_vld;
    logic [4:0]  wa, ra, rb, issue_rd;
    logic [31:0] wd, bus_a, bus_b;
    logic        busy_a, busy_b;
    logic [5:0]  busy_cnt;

    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          n_chk = 0;
    int          n_fail = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .ovf(ovf), .wa(wa), .wd(wd),
        .ra(ra), .rb(rb), .bus_a(bus_a), .bus_b(bus_b),
        .issue_vld(issue_vld), .issue_rd(issue_rd), .flush(flush),
        .busy_a(busy_a), .busy_b(busy_b), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_mem[28] = 32'h0000_1800;
        m_mem[29] = 32'h0000_2ffc;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (we && !ovf && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        return {31'b0, m_busy[a] && !(we && wa == a)};
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic drive(input logic w, input logic o, input logic [4:0] a_wa,
                         input logic [31:0] a_wd, input logic [4:0] a_ra,
                         input logic [4:0] a_rb, input logic iv,
                         input logic [4:0] ird, input logic fl);
        we = w; ovf = o; wa = a_wa; wd = a_wd; ra = a_ra; rb = a_rb;
        issue_vld = iv; issue_rd = ird; flush = fl;
        #1;
        chk("bus_a", bus_a, exp_read(ra));
        chk("bus_b", bus_b, exp_read(rb));
        chk("busy_a", {31'b0, busy_a}, exp_busy(ra));
        chk("busy_b", {31'b0, busy_b}, exp_busy(rb));
        chk("busy_cnt", {26'b0, busy_cnt}, 32'(m_count()));
    endtask

    task automatic idle(input logic [4:0] a_ra, input logic [4:0] a_rb);
        drive(1'b0, 1'b0, 5'd0, 32'h0, a_ra, a_rb, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (we && !ovf && wa != 5'd0) m_mem[wa] = wd;
            if (flush)
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            if (we) m_busy[wa] = 1'b0;
            if (issue_vld && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        int cnt0;
        logic [4:0] r_wa, r_ra, r_rb;

        rst = 1'b1; we = 0; ovf = 0; wa = 0; wd = 0; ra = 0; rb = 0;
        issue_vld = 0; issue_rd = 0; flush = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(5'd28, 5'd29);
        chk("rst_gp", bus_a, 32'h0000_1800);
        chk("rst_sp", bus_b, 32'h0000_2ffc);

        // Write with same-cycle bypass, then stored value
        drive(1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        chk("byp_a", bus_a, 32'hDEAD_BEEF);
        chk("byp_b", bus_b, 32'hDEAD_BEEF);
        tick();
        idle(5'd7, 5'd0);
        chk("stored7", bus_a, 32'hDEAD_BEEF);

        // Overflow suppression with r7=5 and r7 busy
        drive(1'b1, 1'b0, 5'd7, 32'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
        tick();
        idle(5'd7, 5'd7);
        chk("busy7_set", {31'b0, busy_a}, 32'd1);
        drive(1'b1, 1'b1, 5'd7, 32'd1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        chk("ovf_during", bus_a, 32'd5);
        tick();
        idle(5'd7, 5'd7);
        chk("ovf_after", bus_a, 32'd5);
        chk("ovf_busy_clr", {31'b0, busy_a}, 32'd0);
        chk("ovf_cnt", {26'b0, busy_cnt}, 32'd0);

        // Register 0 is immutable and never busy
        cnt0 = int'(busy_cnt);
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        chk("r0_during", bus_a, 32'h0);
        tick();
        idle(5'd0, 5'd0);
        chk("r0_after", bus_a, 32'h0);
        chk("r0_cnt", {26'b0, busy_cnt}, 32'(cnt0));

        // Scoreboard: issue/writeback interplay
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        tick();
        idle(5'd3, 5'd4);
        chk("sb_cnt2", {26'b0, busy_cnt}, 32'd2);
        chk("sb_busy3", {31'b0, busy_a}, 32'd1);
        drive(1'b1, 1'b0, 5'd3, 32'h33, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
        chk("sb_wb3_same", {31'b0, busy_a}, 32'd0);
        tick();
        idle(5'd3, 5'd4);
        chk("sb_cnt1", {26'b0, busy_cnt}, 32'd1);
        drive(1'b1, 1'b0, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        tick();
        idle(5'd4, 5'd4);
        chk("sb_set_wins", {31'b0, busy_a}, 32'd1);

        // Flush with coincident issue
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        tick();
        idle(5'd9, 5'd3);
        chk("fl_cnt3", {26'b0, busy_cnt}, 32'd3);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1);
        tick();
        idle(5'd9, 5'd4);
        chk("fl_cnt1", {26'b0, busy_cnt}, 32'd1);
        chk("fl_busy9", {31'b0, busy_a}, 32'd1);
        chk("fl_busy4", {31'b0, busy_b}, 32'd0);

        // Mid-run asynchronous reset with coincident activity
        rst = 1'b1;
        #1;
        model_reset();
        chk("mrst_gp", bus_a === 32'h0 ? 32'h0 : 32'h0, 32'h0);
        ra = 5'd28; rb = 5'd29; #1;
        chk("mrst_gp", bus_a, 32'h0000_1800);
        chk("mrst_sp", bus_b, 32'h0000_2ffc);
        chk("mrst_cnt", {26'b0, busy_cnt}, 32'd0);
        we = 1; wa = 5'd5; wd = 32'h1234_5678; issue_vld = 1; issue_rd = 5'd6; flush = 1; ra = 5'd5; rb = 5'd6;
        tick();
        we = 0; issue_vld = 0; flush = 0; #1;
        chk("mrst_r5", bus_a, 32'h0);
        chk("mrst_busy6", {31'b0, busy_b}, 32'd0);
        chk("mrst_cnt2", {26'b0, busy_cnt}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 32'hCAFE_0005, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        tick();
        idle(5'd5, 5'd6);
        chk("post_rst_r5", bus_a, 32'hCAFE_0005);
        chk("post_rst_busy6", {31'b0, busy_b}, 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r_wa = 5'($urandom_range(0, 31));
            r_ra = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_rb = ($urandom_range(0, 3) == 0) ? r_ra : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), r_wa, $urandom,
                  r_ra, r_rb, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
